ahb_slave_port_arbiter: RTL and testbench
=========================================

Name: ahb_slave_port_arbiter

Overview:
- Per-slave address-phase arbiter for the AHB multi-master interconnect; one instance sits in front of each slave port.
- Chooses one master from the requests decoded to this slave, using round-robin.
- Holds the grant for fixed-length bursts, undefined-length INCR bursts and locked sequences.
- Tracks the address-phase and data-phase owners so the interconnect can steer hwdata, hrdata, hresp and hready.

Parameters:
- NO_OF_MASTERS, 4, number of requesting masters (>=2).
- MAX_HOLD, 16, max address-phase beats for one INCR tenure (used only with ARB_MAX_HOLD_EN).

Ports:
- hclk  in  1  clock.
- hreset  in  1  reset: synchronous, active-high. One clock; reset is synchronous and active-high.
- req  in  NO_OF_MASTERS  per master: htrans!=IDLE and address decodes to this slave.
- htrans  in  2*NO_OF_MASTERS  per-master htrans.
- hburst  in  3*NO_OF_MASTERS  per-master hburst.
- hmastlock  in  NO_OF_MASTERS  per-master lock.
- hready  in  1  slave hreadyout (transfer-accept strobe).
- grant  out  NO_OF_MASTERS  one-hot address-phase grant, registered.
- addr_owner  out  clog2(NO_OF_MASTERS)  index of the granted master.
- addr_valid  out  1  grant is non-zero.
- data_owner  out  clog2(NO_OF_MASTERS)  master owning the current data phase.
- data_valid  out  1  a data phase is in progress.
- locked  out  1  arbiter is in the LOCKED state.

Behaviour:
- Reset (hreset=1 at posedge hclk):
  - grant=0, addr_valid=0, addr_owner=0, data_owner=0, data_valid=0, locked=0.
  - rr_ptr=0, beat_cnt=0, state=IDLE.
- All state updates occur only on a hclk edge where hready=1. When hready=0, all outputs and internal state hold.
- Accepted transfer: hready=1 and addr_valid=1 and owner htrans in {NONSEQ, SEQ}.
- Data tracking:
  - On an accepted transfer: data_owner<=addr_owner, data_valid<=1.
  - On any other hready=1 edge: data_valid<=0.
- States:
  - IDLE: no owner.
  - BURST: fixed-length burst in progress.
  - INCR: undefined-length burst in progress.
  - LOCKED: owner holds the port through a locked sequence.
- Arbitration point (new grant computed from req): state=IDLE, or the owner's tenure ends this edge.
- Winner selection:
  - If any requester has hmastlock=1, the first locked requester from rr_ptr wins.
  - Otherwise, the first requester from rr_ptr upward (modulo NO_OF_MASTERS) wins.
  - No request: grant<=0, state<=IDLE.
  - On a win: grant<=onehot, addr_owner<=winner, rr_ptr<=winner+1 (wraps to 0).
- Tenure start on the owner's NONSEQ accept:
  - hmastlock=1 -> LOCKED.
  - hburst=SINGLE -> tenure ends this edge.
  - hburst=INCR -> INCR.
  - hburst=WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16 -> BURST with beat_cnt = 3, 7, 15 respectively.
- BURST:
  - Each accepted SEQ decrements beat_cnt.
  - BUSY holds beat_cnt and grant.
  - The accept with beat_cnt=1 ends the tenure, i.e. the last beat re-arbitrates in the same edge.
  - An owner htrans of IDLE or NONSEQ (early termination) ends the tenure immediately; NONSEQ is then treated as a new request.
- INCR: holds while owner htrans in {SEQ, BUSY}. IDLE or NONSEQ ends the tenure.
- LOCKED: holds while the owner has hmastlock=1, including IDLE beats. The first hready edge with hmastlock=0 ends the tenure. Other masters' locks are ignored while LOCKED.
- Granted master drops req while not in BURST/LOCKED: tenure ends; re-arbitrate on the same edge.
- Simultaneous end-of-tenure and new requests: the new winner is granted on that edge, with no idle bubble.
- Reset asserted mid-burst returns to the reset values on the next edge; any partial burst is discarded.
- grant is always one-hot or zero; assert this in RTL.

Optional Feature:
- ARB_MAX_HOLD_EN
  - Defined: an INCR tenure (not LOCKED, not BURST) that reaches MAX_HOLD accepted beats is forced to re-arbitrate at the next accepted beat if another master requests; otherwise it continues and the hold counter restarts. The hold counter resets on every new grant.
  - Undefined: INCR tenure is unbounded; the MAX_HOLD parameter is unused.

Decomposition:
- Shared package (AhbGlobalPackage):
  - htrans encodings IDLE/BUSY/NONSEQ/SEQ.
  - hburst encodings.
  - arb_state_e enum {IDLE, BURST, INCR, LOCKED}.
  - Function burst_beats(hburst) returning the beat count.
- Sub-module rr_picker: combinational; inputs req vector, mask (lock filter) and rr_ptr; outputs one-hot pick plus index.

Test Plan:
- req=4'b0110, all SINGLE, hready=1 every cycle -> grants alternate m1, m2, m1...; rr_ptr ends at 2 or 3; data_owner lags addr_owner by one edge.
- m0 INCR4 (NONSEQ + 3 SEQ) with m3 requesting -> m0 keeps grant for 4 accepts; m3 granted on the 4th-accept edge; no gap cycle.
- m2 INCR8 with hready=0 for 3 cycles mid-burst -> grant, beat_cnt and data_owner frozen during the stall; burst completes after 8 accepts.
- m1 hmastlock=1 with two SINGLEs and an IDLE between, m0 requesting -> locked=1, m1 retains grant across the IDLE; m0 granted on the first edge after hmastlock=0.
- m0 WRAP16, hreset=1 asserted at beat 5 -> next edge all outputs are 0 and state=IDLE; fresh requests are granted from rr_ptr=0.
- ARB_MAX_HOLD_EN, MAX_HOLD=4: m0 INCR with 10 SEQs, m1 requesting -> m1 granted after m0's 5th accept; without the macro, m0 holds all 11 beats.

Source files
------------

// File: rtl/ahb_slave_port_arbiter_pkg.sv
// ahb_slave_port_arbiter_pkg
//   Shared AHB definitions for the slave-port arbiter:
//   - htrans / hburst encodings
//   - arb_state_e arbiter tenure states
//   - burst_beats(): number of beats implied by an hburst code
//     (0 for undefined-length INCR)
package ahb_slave_port_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BURST  = 2'd1,
        ARB_INCR   = 2'd2,
        ARB_LOCKED = 2'd3
    } arb_state_e;

    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_SINGLE:               return 5'd1;
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                     return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_port_arbiter_if.sv
// ahb_slave_port_arbiter_if
//   Bus bundle between the interconnect and one slave-port arbiter.
//   master modport: interconnect side (drives requests, sees grants)
//   slave  modport: arbiter side
//   Signals: req, htrans, hburst, hmastlock (per master), hready,
//            grant, addr_owner, addr_valid, data_owner, data_valid, locked.
interface ahb_slave_port_arbiter_if #(
    parameter int NO_OF_MASTERS = 4
) ();
    localparam int IW = $clog2(NO_OF_MASTERS);

    logic [NO_OF_MASTERS-1:0]      req;
    logic [NO_OF_MASTERS-1:0][1:0] htrans;
    logic [NO_OF_MASTERS-1:0][2:0] hburst;
    logic [NO_OF_MASTERS-1:0]      hmastlock;
    logic                          hready;
    logic [NO_OF_MASTERS-1:0]      grant;
    logic [IW-1:0]                 addr_owner;
    logic                          addr_valid;
    logic [IW-1:0]                 data_owner;
    logic                          data_valid;
    logic                          locked;

    modport master (
        output req, htrans, hburst, hmastlock, hready,
        input  grant, addr_owner, addr_valid, data_owner, data_valid, locked
    );

    modport slave (
        input  req, htrans, hburst, hmastlock, hready,
        output grant, addr_owner, addr_valid, data_owner, data_valid, locked
    );
endinterface

// File: rtl/ahb_slave_port_arbiter_rr_picker.sv
// ahb_slave_port_arbiter_rr_picker
//   Combinational round-robin picker: first set bit of (req & mask)
//   searching upward from rr_ptr, modulo N.
//   Ports: req, mask, rr_ptr in; pick (one-hot), pick_idx, any out.
module ahb_slave_port_arbiter_rr_picker #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx,
    output logic          any
);
    logic [N-1:0] cand;

    assign cand = req & mask;
    assign any  = |cand;

    // Scan offsets from farthest to nearest; the nearest candidate is
    // written last and therefore wins.
    always_comb begin
        int j;
        j        = 0;
        pick     = '0;
        pick_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= N) j = j - N;
            if (cand[j]) begin
                pick     = '0;
                pick[j]  = 1'b1;
                pick_idx = j[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/ahb_slave_port_arbiter.sv
// ahb_slave_port_arbiter
//   Per-slave address-phase arbiter. Round-robin among requesters (locked
//   requesters first), holds the grant through fixed bursts, INCR bursts and
//   locked sequences, and tracks address/data-phase owners.
//   Ports: hclk, hreset (sync, active-high), bus (slave modport).
//   Optional macro ARB_MAX_HOLD_EN: bounds an INCR tenure to MAX_HOLD beats
//   when another master is waiting.
module ahb_slave_port_arbiter
    import ahb_slave_port_arbiter_pkg::*;
#(
    parameter int NO_OF_MASTERS = 4,
    parameter int MAX_HOLD      = 16
) (
    input logic                   hclk,
    input logic                   hreset,
    ahb_slave_port_arbiter_if.slave bus
);
    localparam int IW = $clog2(NO_OF_MASTERS);

    arb_state_e               state_q, state_d;
    logic [NO_OF_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]            addr_owner_q, addr_owner_d;
    logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [3:0]               beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]            data_owner_q, data_owner_d;
    logic                     data_valid_q, data_valid_d;
    logic                     rearb;

`ifdef ARB_MAX_HOLD_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              others_req;
    assign others_req = |(bus.req & ~grant_q);
`endif

    logic       addr_valid;
    logic [1:0] own_htrans;
    logic [2:0] own_hburst;
    logic       own_lock, own_req, xfer;

    assign addr_valid = |grant_q;
    assign own_htrans = bus.htrans[addr_owner_q];
    assign own_hburst = bus.hburst[addr_owner_q];
    assign own_lock   = bus.hmastlock[addr_owner_q];
    assign own_req    = bus.req[addr_owner_q];
    assign xfer       = bus.hready && addr_valid &&
                        (own_htrans == HTRANS_NONSEQ || own_htrans == HTRANS_SEQ);

    // Locked requesters take precedence; otherwise everyone is eligible.
    logic [NO_OF_MASTERS-1:0] lock_mask, pick;
    logic [IW-1:0]            pick_idx;
    logic                     pick_any;

    assign lock_mask = (|(bus.req & bus.hmastlock)) ? bus.hmastlock : '1;

    ahb_slave_port_arbiter_rr_picker #(.N(NO_OF_MASTERS)) u_picker (
        .req      (bus.req),
        .mask     (lock_mask),
        .rr_ptr   (rr_ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    // State register: everything advances only on hready edges.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            addr_owner_q <= '0;
            rr_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            data_owner_q <= '0;
            data_valid_q <= 1'b0;
`ifdef ARB_MAX_HOLD_EN
            hold_cnt_q   <= '0;
`endif
        end else if (bus.hready) begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            addr_owner_q <= addr_owner_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            data_owner_q <= data_owner_d;
            data_valid_q <= data_valid_d;
`ifdef ARB_MAX_HOLD_EN
            hold_cnt_q   <= hold_cnt_d;
`endif
        end
    end

    // Next-state: decide whether the current tenure continues or the port
    // re-arbitrates on this edge.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rearb      = 1'b0;
`ifdef ARB_MAX_HOLD_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                // A grant is waiting for its NONSEQ; anything else re-arbitrates.
                if (xfer && own_req && own_htrans == HTRANS_NONSEQ) begin
                    if (own_lock) begin
                        state_d = ARB_LOCKED;
                    end else if (own_hburst == HBURST_SINGLE) begin
                        rearb = 1'b1;
                    end else if (own_hburst == HBURST_INCR) begin
                        state_d = ARB_INCR;
`ifdef ARB_MAX_HOLD_EN
                        hold_cnt_d = HOLD_W'(1);
`endif
                    end else begin
                        state_d    = ARB_BURST;
                        beat_cnt_d = 4'(burst_beats(own_hburst) - 5'd1);
                    end
                end else begin
                    rearb = 1'b1;
                end
            end
            ARB_BURST: begin
                if (own_htrans == HTRANS_SEQ) begin
                    if (beat_cnt_q == 4'd1) rearb = 1'b1;
                    else                    beat_cnt_d = beat_cnt_q - 4'd1;
                end else if (own_htrans != HTRANS_BUSY) begin
                    rearb = 1'b1;       // early termination
                end
            end
            ARB_INCR: begin
                if (!own_req || !(own_htrans == HTRANS_SEQ || own_htrans == HTRANS_BUSY)) begin
                    rearb = 1'b1;
                end
`ifdef ARB_MAX_HOLD_EN
                else if (own_htrans == HTRANS_SEQ) begin
                    // Budget spent: yield if someone waits, else start a new budget.
                    if (hold_cnt_q >= HOLD_W'(MAX_HOLD)) begin
                        if (others_req) rearb = 1'b1;
                        else            hold_cnt_d = HOLD_W'(1);
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
`endif
            end
            ARB_LOCKED: begin
                if (!own_lock) rearb = 1'b1;
            end
            default: rearb = 1'b1;
        endcase

        if (rearb) begin
            state_d    = ARB_IDLE;
            beat_cnt_d = '0;
`ifdef ARB_MAX_HOLD_EN
            hold_cnt_d = '0;
`endif
        end
    end

    // Output/grant update.
    always_comb begin
        grant_d      = grant_q;
        addr_owner_d = addr_owner_q;
        rr_ptr_d     = rr_ptr_q;
        if (rearb) begin
            if (pick_any) begin
                grant_d      = pick;
                addr_owner_d = pick_idx;
                rr_ptr_d     = (pick_idx == IW'(NO_OF_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
            end else begin
                grant_d = '0;
            end
        end
        data_valid_d = xfer;
        data_owner_d = xfer ? addr_owner_q : data_owner_q;
    end

    assign bus.grant      = grant_q;
    assign bus.addr_owner = addr_owner_q;
    assign bus.addr_valid = addr_valid;
    assign bus.data_owner = data_owner_q;
    assign bus.data_valid = data_valid_q;
    assign bus.locked     = (state_q == ARB_LOCKED);

    always_ff @(posedge hclk) begin
        assert (NO_OF_MASTERS >= 2 && MAX_HOLD >= 1);
        if (!hreset) assert ($onehot0(grant_q));
    end
endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// tb_ahb_slave_port_arbiter
//   Directed tests for ahb_slave_port_arbiter (4 masters, MAX_HOLD=4).
//   Observed vector per edge: {grant[3:0], addr_owner, addr_valid,
//   data_owner, data_valid, locked}. Honors ARB_MAX_HOLD_EN.
module tb_ahb_slave_port_arbiter;
    import ahb_slave_port_arbiter_pkg::*;

    logic hclk = 1'b0;
    logic hreset;
    int   passed = 0;
    int   total  = 0;

    ahb_slave_port_arbiter_if #(.NO_OF_MASTERS(4)) bus ();

    ahb_slave_port_arbiter #(.NO_OF_MASTERS(4), .MAX_HOLD(4)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    function automatic logic [10:0] obs();
        return {bus.grant, bus.addr_owner, bus.addr_valid, bus.data_owner, bus.data_valid, bus.locked};
    endfunction

    function automatic logic [10:0] vec(logic [3:0] g, int ao, bit av, int dn, bit dv, bit lk);
        return {g, 2'(ao), av, 2'(dn), dv, lk};
    endfunction

    task automatic drive(int m, logic [1:0] t, logic [2:0] b, logic l);
        bus.htrans[m]    = t;
        bus.hburst[m]    = b;
        bus.hmastlock[m] = l;
        bus.req[m]       = (t != HTRANS_IDLE);
    endtask

    task automatic idle_all();
        for (int m = 0; m < 4; m++) drive(m, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreset     = 1'b1;
        bus.hready = 1'b1;
        idle_all();
        tick();
        hreset = 1'b0;
    endtask

    task automatic test_reset();
        hreset     = 1'b1;
        bus.hready = 1'b1;
        idle_all();
        drive(0, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        for (int e = 0; e < 2; e++) begin
            tick();
            total++;
            if (obs() !== 11'd0) $display("FAIL reset edge%0d: got %b want %b", e + 1, obs(), 11'd0);
            else passed++;
        end
        hreset = 1'b0;
        idle_all();
    endtask

    task automatic test_rr_single();
        logic [10:0] exp [5];
        do_reset();
        exp = '{vec(4'b0010, 1, 1, 0, 0, 0), vec(4'b0100, 2, 1, 1, 1, 0),
                vec(4'b0010, 1, 1, 2, 1, 0), vec(4'b0100, 2, 1, 1, 1, 0),
                vec(4'b0000, 2, 0, 1, 0, 0)};
        drive(1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
        drive(2, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
        for (int e = 0; e < 5; e++) begin
            if (e == 4) idle_all();
            tick();
            total++;
            if (obs() !== exp[e]) $display("FAIL rr_single edge%0d: got %b want %b", e + 1, obs(), exp[e]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp [6];
        do_reset();
        exp = '{vec(4'b0001, 0, 1, 0, 0, 0), vec(4'b0001, 0, 1, 0, 1, 0),
                vec(4'b0001, 0, 1, 0, 1, 0), vec(4'b0001, 0, 1, 0, 1, 0),
                vec(4'b1000, 3, 1, 0, 1, 0), vec(4'b1000, 3, 1, 3, 1, 0)};
        drive(0, HTRANS_NONSEQ, HBURST_INCR4, 1'b0);
        drive(3, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
        for (int e = 0; e < 6; e++) begin
            if (e == 2) drive(0, HTRANS_SEQ, HBURST_INCR4, 1'b0);
            if (e == 5) drive(0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
            tick();
            total++;
            if (obs() !== exp[e]) $display("FAIL back_to_back edge%0d: got %b want %b", e + 1, obs(), exp[e]);
            else passed++;
        end
        idle_all();
    endtask

    task automatic test_hready_stall();
        logic [10:0] exp;
        do_reset();
        drive(2, HTRANS_NONSEQ, HBURST_INCR8, 1'b0);
        for (int e = 0; e < 12; e++) begin
            if (e == 1) drive(0, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
            if (e == 2) drive(2, HTRANS_SEQ, HBURST_INCR8, 1'b0);
            bus.hready = !(e >= 4 && e <= 6);
            if (e == 0)       exp = vec(4'b0100, 2, 1, 0, 0, 0);
            else if (e == 11) exp = vec(4'b0001, 0, 1, 2, 1, 0);
            else              exp = vec(4'b0100, 2, 1, 2, 1, 0);
            tick();
            total++;
            if (obs() !== exp) $display("FAIL hready_stall edge%0d: got %b want %b", e + 1, obs(), exp);
            else passed++;
        end
        bus.hready = 1'b1;
        idle_all();
    endtask

    task automatic test_locked();
        logic [10:0] exp [5];
        do_reset();
        exp = '{vec(4'b0010, 1, 1, 0, 0, 0), vec(4'b0010, 1, 1, 1, 1, 1),
                vec(4'b0010, 1, 1, 1, 0, 1), vec(4'b0010, 1, 1, 1, 1, 1),
                vec(4'b0001, 0, 1, 1, 0, 0)};
        drive(1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        drive(0, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
        for (int e = 0; e < 5; e++) begin
            if (e == 2) drive(1, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
            if (e == 3) drive(1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
            if (e == 4) drive(1, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
            tick();
            total++;
            if (obs() !== exp[e]) $display("FAIL locked edge%0d: got %b want %b", e + 1, obs(), exp[e]);
            else passed++;
        end
        idle_all();
    endtask

    task automatic test_reset_midburst();
        logic [10:0] exp [8];
        do_reset();
        exp = '{vec(4'b0001, 0, 1, 0, 0, 0), vec(4'b0001, 0, 1, 0, 1, 0),
                vec(4'b0001, 0, 1, 0, 1, 0), vec(4'b0001, 0, 1, 0, 1, 0),
                vec(4'b0001, 0, 1, 0, 1, 0), vec(4'b0000, 0, 0, 0, 0, 0),
                vec(4'b0001, 0, 1, 0, 0, 0), vec(4'b1000, 3, 1, 0, 1, 0)};
        drive(0, HTRANS_NONSEQ, HBURST_WRAP16, 1'b0);
        for (int e = 0; e < 8; e++) begin
            if (e == 2) drive(0, HTRANS_SEQ, HBURST_WRAP16, 1'b0);
            if (e == 5) hreset = 1'b1;
            if (e == 6) begin
                hreset = 1'b0;
                drive(0, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
                drive(3, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
            end
            tick();
            total++;
            if (obs() !== exp[e]) $display("FAIL reset_midburst edge%0d: got %b want %b", e + 1, obs(), exp[e]);
            else passed++;
        end
        idle_all();
    endtask

    task automatic test_incr_hold();
        logic [10:0] exp;
        do_reset();
        drive(0, HTRANS_NONSEQ, HBURST_INCR, 1'b0);
        drive(1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
        tick();
        total++;
        exp = vec(4'b0001, 0, 1, 0, 0, 0);
        if (obs() !== exp) $display("FAIL incr_grant: got %b want %b", obs(), exp);
        else passed++;
        for (int k = 1; k <= 11; k++) begin
            if (k == 2) drive(0, HTRANS_SEQ, HBURST_INCR, 1'b0);
`ifdef ARB_MAX_HOLD_EN
            exp = (k == 5) ? vec(4'b0010, 1, 1, 0, 1, 0) : vec(4'b0001, 0, 1, 0, 1, 0);
`else
            exp = vec(4'b0001, 0, 1, 0, 1, 0);
`endif
            tick();
            total++;
            if (obs() !== exp) $display("FAIL incr_hold accept%0d: got %b want %b", k, obs(), exp);
            else passed++;
`ifdef ARB_MAX_HOLD_EN
            if (k == 5) break;
`endif
        end
`ifndef ARB_MAX_HOLD_EN
        drive(0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
        tick();
        total++;
        exp = vec(4'b0010, 1, 1, 0, 0, 0);
        if (obs() !== exp) $display("FAIL incr_end: got %b want %b", obs(), exp);
        else passed++;
`endif
        idle_all();
    endtask

    initial begin
        hreset     = 1'b1;
        bus.hready = 1'b1;
        idle_all();
        test_reset();
        test_rr_single();
        test_back_to_back();
        test_hready_stall();
        test_locked();
        test_reset_midburst();
        test_incr_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
